// File: rtl/i281_code_loader_if.sv
// Byte-stream handshake bundle for the i281 code loader.
// The master drives program bytes; the slave (the loader) drives byte_ready.
interface i281_code_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/i281_code_loader.sv
// Writable 32-word i281 instruction store with a byte-stream load controller.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum byte and load_err.
module i281_code_loader #(
    parameter int          DEPTH = 32,
    parameter logic [15:0] NOOP  = 16'h0000
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 load_start,
    input  logic [4:0]           load_base,
    input  logic [5:0]           load_len,
    i281_code_loader_if.slave    bs,
    input  logic [4:0]           pc_addr,
    output logic [15:0]          instr_out,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_err
);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
`ifdef LOADER_CHECKSUM_EN
        CK,
`endif
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic [5:0]  remain_q, remain_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] mem_q [DEPTH];
    logic        we;
    logic [15:0] wdata;
    logic        ready;
    logic        accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        err_q, err_d;
`endif

    // Stream is accepted in any byte-consuming state; never depends on valid.
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            HI:      ready = 1'b1;
            LO:      ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CK:      ready = 1'b1;
`endif
            default: ready = 1'b0;
        endcase
    end

    assign bs.byte_ready = ready;
    assign accept        = bs.byte_valid & ready;

    // Next-state, address/count and checksum sequencing for a load.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        hi_d     = hi_q;
        we       = 1'b0;
        wdata    = {hi_q, bs.byte_in};
`ifdef LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load_start && load_len != 6'd0) begin
                    addr_d   = load_base;
                    remain_d = load_len;
                    state_d  = HI;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = 8'h00;
                    err_d    = 1'b0;
`endif
                end
            end
            HI: begin
                if (accept) begin
                    hi_d    = bs.byte_in;
                    state_d = LO;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + bs.byte_in;
`endif
                end
            end
            LO: begin
                if (accept) begin
                    we       = 1'b1;
                    addr_d   = addr_q + 5'd1;
                    remain_d = remain_q - 6'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = sum_q + bs.byte_in;
                    state_d  = (remain_q == 6'd1) ? CK : HI;
`else
                    state_d  = (remain_q == 6'd1) ? DONE : HI;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CK: begin
                if (accept) begin
                    if (bs.byte_in != sum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            addr_q   <= 5'd0;
            remain_q <= 6'd0;
            hi_q     <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= 8'h00;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            hi_q     <= hi_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
            err_q    <= err_d;
`endif
        end
    end

    // Instruction store; reset wipes every word, including partial loads.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (we) begin
            mem_q[addr_q] <= wdata;
        end
    end

    assign cpu_hold  = (state_q != IDLE);
    assign load_done = (state_q == DONE);
    assign instr_out = cpu_hold ? NOOP : mem_q[pc_addr];

`ifdef LOADER_CHECKSUM_EN
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_i281_code_loader.sv
// Self-checking bench for i281_code_loader: table vectors, corner sequences,
// and random loads checked against an array model of the instruction store.
module tb_i281_code_loader;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        load_start;
    logic [4:0]  load_base;
    logic [5:0]  load_len;
    logic [4:0]  pc_addr;
    logic [15:0] instr_out;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    i281_code_loader_if bs_if ();

    i281_code_loader dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .bs         (bs_if.slave),
        .pc_addr    (pc_addr),
        .instr_out  (instr_out),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    logic [15:0] model_mem [32];
    logic        model_err;
    logic [15:0] ld_w [32];

    typedef struct {
        logic [4:0]  base;
        logic [5:0]  len;
        logic [15:0] w [4];
        int          max_gap;
        bit          mid_start;
        logic [4:0]  chk_addr;
        logic [15:0] chk_val;
    } vec_t;

    vec_t vt [3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        bs_if.byte_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge Clock);
        bs_if.byte_in    = b;
        bs_if.byte_valid = 1'b1;
        n = 0;
        while (bs_if.byte_ready !== 1'b1 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
        @(negedge Clock);
        bs_if.byte_valid = 1'b0;
    endtask

    task automatic sweep(input string nm);
        for (int a = 0; a < 32; a++) begin
            pc_addr = a[4:0];
            #1;
            chk(nm, instr_out, model_mem[a]);
        end
        @(negedge Clock);
    endtask

    task automatic run_load(input logic [4:0] base, input logic [5:0] len,
                            input int max_gap, input bit mid_start,
                            input bit bad_ck);
        logic [7:0] sum;
        logic [4:0] a;
        sum = 8'h00;
        load_base  = base;
        load_len   = len;
        load_start = 1'b1;
        @(negedge Clock);
        load_start = 1'b0;
        chk("hold_on_start", cpu_hold, 1);
        chk("ready_on_start", bs_if.byte_ready, 1);
        chk("err_clear_on_start", load_err, 0);
        model_err = 1'b0;
        a = base;
        for (int i = 0; i < int'(len); i++) begin
            if (mid_start && i == int'(len) / 2) begin
                load_start = 1'b1;
                load_base  = ~base;
                load_len   = 6'd1;
                @(negedge Clock);
                load_start = 1'b0;
                chk("mid_start_ignored", cpu_hold, 1);
            end
            pc_addr = a;
            #1;
            chk("noop_during_load", instr_out, 16'h0000);
            chk("no_done_mid_load", load_done, 0);
            send_byte(ld_w[i][15:8], max_gap);
            send_byte(ld_w[i][7:0], max_gap);
            sum = sum + ld_w[i][15:8] + ld_w[i][7:0];
            model_mem[a] = ld_w[i];
            a = a + 5'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_ck ? sum + 8'd1 : sum, max_gap);
        model_err = bad_ck;
`endif
        chk("done_pulse", load_done, 1);
        chk("hold_in_done", cpu_hold, 1);
        @(negedge Clock);
        chk("done_single", load_done, 0);
        chk("hold_released", cpu_hold, 0);
        chk("ready_idle", bs_if.byte_ready, 0);
        chk("load_err", load_err, model_err);
    endtask

    initial begin
        load_start       = 1'b0;
        load_base        = 5'd0;
        load_len         = 6'd0;
        pc_addr          = 5'd0;
        bs_if.byte_in    = 8'h00;
        bs_if.byte_valid = 1'b0;
        model_err        = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = 16'h0000;

        vt[0] = '{5'd0, 6'd2, '{16'hD300, 16'hF104, 16'h0, 16'h0},
                  0, 1'b0, 5'd1, 16'hF104};
        vt[1] = '{5'd31, 6'd2, '{16'h3C00, 16'h8A0C, 16'h0, 16'h0},
                  0, 1'b0, 5'd0, 16'h8A0C};
        vt[2] = '{5'd30, 6'd4, '{16'h1111, 16'h2222, 16'h3333, 16'h4444},
                  3, 1'b1, 5'd1, 16'h4444};

        #2;
        chk("rst_ready", bs_if.byte_ready, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        sweep("rst_sweep");

        load_base  = 5'd3;
        load_len   = 6'd0;
        load_start = 1'b1;
        @(negedge Clock);
        load_start = 1'b0;
        chk("len0_hold", cpu_hold, 0);
        chk("len0_ready", bs_if.byte_ready, 0);
        chk("len0_done", load_done, 0);
        @(negedge Clock);
        chk("len0_done2", load_done, 0);

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 4; i++) ld_w[i] = vt[v].w[i];
            run_load(vt[v].base, vt[v].len, vt[v].max_gap,
                     vt[v].mid_start, 1'b0);
            pc_addr = vt[v].chk_addr;
            #1;
            chk("vec_word", instr_out, vt[v].chk_val);
            @(negedge Clock);
            sweep("vec_sweep");
        end

`ifdef LOADER_CHECKSUM_EN
        ld_w[0] = 16'hA55A;
        ld_w[1] = 16'h0F0F;
        run_load(5'd10, 6'd2, 1, 1'b0, 1'b1);
        sweep("badck_sweep");
        @(negedge Clock);
        chk("err_sticky", load_err, 1);
        ld_w[0] = 16'h1234;
        run_load(5'd12, 6'd1, 0, 1'b0, 1'b0);
        sweep("goodck_sweep");
`endif

        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) ld_w[i] = 16'($urandom);
            run_load(5'($urandom_range(0, 31)), 6'(len), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            sweep("rand_sweep");
        end

        load_base  = 5'd5;
        load_len   = 6'd4;
        load_start = 1'b1;
        @(negedge Clock);
        load_start = 1'b0;
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        Reset_n = 1'b0;
        #1;
        chk("midrst_ready", bs_if.byte_ready, 0);
        chk("midrst_hold", cpu_hold, 0);
        chk("midrst_done", load_done, 0);
        chk("midrst_err", load_err, 0);
        pc_addr = 5'd5;
        #1;
        chk("midrst_mem_base", instr_out, 16'h0000);
        @(negedge Clock);
        Reset_n = 1'b1;
        for (int i = 0; i < 32; i++) model_mem[i] = 16'h0000;
        @(negedge Clock);
        chk("midrst_idle_ready", bs_if.byte_ready, 0);
        sweep("midrst_sweep");
        ld_w[0] = 16'hC0DE;
        run_load(5'd5, 6'd1, 0, 1'b0, 1'b0);
        sweep("post_rst_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
